// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// keypad_scan : 4x4 active-low keypad scanner with press/release debounce
// Revision    : 1.0
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [4:0] keycode,
    output logic       key_ready
);

    localparam int                SLOT_W        = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] c_slot_last   = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        c_deb_target  = 4'(DEBOUNCE_CNT);
    localparam bit                c_first_done  = (DEBOUNCE_CNT <= 1);
    localparam logic [4:0]        c_no_key      = 5'h10;

    typedef enum logic [2:0] {
        ST_SCAN  = 3'd0,
        ST_DEB_P = 3'd1,
        ST_HELD  = 3'd2,
        ST_DEB_R = 3'd3,
        ST_DROP  = 3'd4
    } state_t;

    state_t             r_state;
    logic [3:0]         r_sync1;
    logic [3:0]         r_sync2;
    logic [SLOT_W-1:0]  r_slot;
    logic [3:0]         r_cand;
    logic [3:0]         r_deb;
    logic [1:0]         r_drop;

    logic               w_slot_end;
    logic               w_valid;
    logic [3:0]         w_deb_inc;
    logic               w_deb_done;
    logic [3:0]         w_col_next;

    function automatic logic [4:0] key_of(input logic [3:0] rows, input logic [3:0] cols);
        logic [1:0] ri;
        logic [1:0] ci;
        ri = 2'd0;
        ci = 2'd0;
        case (rows)
            4'b1101: ri = 2'd1;
            4'b1011: ri = 2'd2;
            4'b0111: ri = 2'd3;
            default: ri = 2'd0;
        endcase
        case (cols)
            4'b1101: ci = 2'd1;
            4'b1011: ci = 2'd2;
            4'b0111: ci = 2'd3;
            default: ci = 2'd0;
        endcase
        case ({ri, ci})
            4'h0: key_of = 5'd1;   4'h1: key_of = 5'd2;
            4'h2: key_of = 5'd3;   4'h3: key_of = 5'd10;
            4'h4: key_of = 5'd4;   4'h5: key_of = 5'd5;
            4'h6: key_of = 5'd6;   4'h7: key_of = 5'd11;
            4'h8: key_of = 5'd7;   4'h9: key_of = 5'd8;
            4'hA: key_of = 5'd9;   4'hB: key_of = 5'd12;
            4'hC: key_of = 5'd14;  4'hD: key_of = 5'd0;
            4'hE: key_of = 5'd15;  default: key_of = 5'd13;
        endcase
    endfunction

    assign w_slot_end = (r_slot == c_slot_last);
    assign w_valid    = (r_sync2 == 4'b1110) || (r_sync2 == 4'b1101) ||
                        (r_sync2 == 4'b1011) || (r_sync2 == 4'b0111);
    assign w_deb_inc  = (r_deb == 4'hF) ? 4'hF : r_deb + 4'd1;
    assign w_deb_done = (w_deb_inc >= c_deb_target);
    assign w_col_next = {col_out[2:0], col_out[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SCAN;
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_slot    <= '0;
            r_cand    <= 4'hF;
            r_deb     <= 4'd0;
            r_drop    <= 2'd0;
            col_out   <= 4'b1110;
            keycode   <= c_no_key;
            key_ready <= 1'b0;
        end else begin
            r_sync1   <= row_in;
            r_sync2   <= r_sync1;
            key_ready <= (r_state == ST_HELD) || (r_state == ST_DEB_R);
            // Leaving DROP restarts the slot so the new column gets a full settle time.
            if ((r_state == ST_DROP) && (r_drop == 2'd2))
                r_slot <= '0;
            else if (w_slot_end)
                r_slot <= '0;
            else
                r_slot <= r_slot + SLOT_W'(1);

            case (r_state)
                ST_SCAN: begin
                    if (w_slot_end) begin
                        if (w_valid) begin
                            r_cand <= r_sync2;
                            r_deb  <= 4'd1;
                            if (c_first_done) begin
                                keycode <= key_of(r_sync2, col_out);
                                r_state <= ST_HELD;
                            end else begin
                                r_state <= ST_DEB_P;
                            end
                        end else begin
                            col_out <= w_col_next;
                        end
                    end
                end
                ST_DEB_P: begin
                    if (w_slot_end) begin
                        if (r_sync2 == r_cand) begin
                            r_deb <= w_deb_inc;
                            if (w_deb_done) begin
                                keycode <= key_of(r_cand, col_out);
                                r_state <= ST_HELD;
                            end
                        end else begin
                            r_deb   <= 4'd0;
                            col_out <= w_col_next;
                            r_state <= ST_SCAN;
                        end
                    end
                end
                ST_HELD: begin
                    if (w_slot_end && (r_sync2 == 4'hF)) begin
                        r_deb <= 4'd1;
                        if (c_first_done) begin
                            r_drop  <= 2'd0;
                            r_state <= ST_DROP;
                        end else begin
                            r_state <= ST_DEB_R;
                        end
                    end
                end
                ST_DEB_R: begin
                    if (w_slot_end) begin
                        if (r_sync2 == 4'hF) begin
                            r_deb <= w_deb_inc;
                            if (w_deb_done) begin
                                r_drop  <= 2'd0;
                                r_state <= ST_DROP;
                            end
                        end else begin
                            r_deb   <= 4'd0;
                            r_state <= ST_HELD;
                        end
                    end
                end
                ST_DROP: begin
                    // keycode is held two clocks past the key_ready fall for the display sampler.
                    if (r_drop == 2'd2) begin
                        keycode <= c_no_key;
                        r_deb   <= 4'd0;
                        col_out <= w_col_next;
                        r_state <= ST_SCAN;
                    end else begin
                        r_drop <= r_drop + 2'd1;
                    end
                end
                default: r_state <= ST_SCAN;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// tb_keypad_scan : scoreboard bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_CNT=3)
// Revision       : 1.0
// ============================================================================
module tb_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [4:0]  keycode;
    logic        key_ready;
    logic [15:0] pressed;

    int tests = 0;
    int fails = 0;
    int rises = 0;
    int falls = 0;
    logic [4:0] exp_q[$];

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .keycode   (keycode),
        .key_ready (key_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key at row r, column c is bit r*4+c; a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_level(input logic lvl, input string name);
        int n = 0;
        while (key_ready !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (key_ready !== lvl) begin
            fails++;
            $display("FAIL %s: key_ready stuck at %0b, expected %0b", name, key_ready, lvl);
        end
    endtask

    task automatic settle();
        wait_level(1'b0, "release_timeout");
        repeat (8) @(negedge clk);
    endtask

    // Monitor: pops the expected code at each key_ready rise, checks the hand-off at each fall.
    logic       prev_ready = 1'b0;
    logic [4:0] prev_code  = 5'h10;
    logic [4:0] prev2_code = 5'h10;
    logic [4:0] held_code  = 5'h10;
    int         fall_phase = 0;

    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst_n) begin
            fall_phase = 0;
            prev_ready = 1'b0;
        end else begin
            if (fall_phase == 1) begin
                check("drop_hold", keycode, held_code);
                fall_phase = 2;
            end else if (fall_phase == 2) begin
                check("drop_clear", keycode, 5'h10);
                fall_phase = 0;
            end
            if (key_ready && !prev_ready) begin
                rises++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rise: keycode=%0d, expected no key_ready", keycode);
                end else begin
                    e = exp_q.pop_front();
                    check("key_code", keycode, e);
                    check("code_lead", prev_code, e);
                    check("code_pre", prev2_code, 5'h10);
                    held_code = e;
                end
            end
            if (!key_ready && prev_ready) begin
                falls++;
                check("fall_code", keycode, held_code);
                fall_phase = 1;
            end
            prev_ready = key_ready;
        end
        prev2_code = prev_code;
        prev_code  = keycode;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        int r0;
        int f0;
        pressed = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", col_out, 4'b1110);
        check("rst_code", keycode, 5'h10);
        check("rst_ready", key_ready, 0);

        // 1: idle scan rotates one column every 4 clocks
        rst_n = 1'b1;
        exp_col = 4'b1110;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k % 4 == 0) exp_col = {exp_col[2:0], exp_col[3]};
            check("scan_col", col_out, exp_col);
            check("scan_code", keycode, 5'h10);
            check("scan_ready", key_ready, 0);
        end

        // 2: clean press of "5"
        exp_q.push_back(5'd5);
        pressed[5] = 1'b1;
        repeat (40) @(negedge clk);
        check("hold5_ready", key_ready, 1);
        pressed[5] = 1'b0;
        settle();

        // 3: bouncing "#" then stable
        exp_q.push_back(5'd15);
        r0 = rises;
        for (int i = 0; i < 6; i++) begin
            pressed[14] = (i % 2 == 0);
            repeat (5) @(negedge clk);
        end
        pressed[14] = 1'b1;
        repeat (2) @(negedge clk);
        check("bounce_no_ready", rises, r0);
        wait_level(1'b1, "bounce_accept_timeout");
        pressed[14] = 1'b0;
        settle();

        // 4a: "1" and "4" together are never accepted
        r0 = rises;
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        repeat (80) @(negedge clk);
        check("two_keys_rej", rises, r0);
        pressed = '0;
        repeat (8) @(negedge clk);

        // 4b: "1" accepted, "4" added, then released one at a time
        exp_q.push_back(5'd1);
        pressed[0] = 1'b1;
        wait_level(1'b1, "key1_timeout");
        f0 = falls;
        pressed[4] = 1'b1;
        repeat (30) @(negedge clk);
        pressed[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("second_key_falls", falls, f0);
        check("second_key_code", keycode, 5'd1);
        check("second_key_ready", key_ready, 1);
        pressed[4] = 1'b0;
        settle();

        // 5: single-sample release glitch on "0"
        exp_q.push_back(5'd0);
        pressed[13] = 1'b1;
        wait_level(1'b1, "key0_timeout");
        f0 = falls;
        repeat (3) @(negedge clk);
        pressed[13] = 1'b0;
        repeat (4) @(negedge clk);
        pressed[13] = 1'b1;
        repeat (24) @(negedge clk);
        check("glitch_falls", falls, f0);
        check("glitch_code", keycode, 5'd0);
        check("glitch_ready", key_ready, 1);
        pressed[13] = 1'b0;
        settle();

        // 6: asynchronous reset while "D" is held, then reacquire
        exp_q.push_back(5'd13);
        pressed[15] = 1'b1;
        wait_level(1'b1, "keyD_timeout");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ready", key_ready, 0);
        check("arst_code", keycode, 5'h10);
        check("arst_col", col_out, 4'b1110);
        repeat (2) @(negedge clk);
        exp_q.push_back(5'd13);
        rst_n = 1'b1;
        wait_level(1'b1, "reacquire_timeout");
        check("reacquire_code", keycode, 5'd13);
        pressed[15] = 1'b0;
        settle();

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad, debounces presses and releases, and presents one key at a time as a 5-bit `keycode` with a `key_ready` level. It sits directly upstream of the four-digit display logic. That consumer samples `keycode` on the falling edge of `key_ready` and treats codes 0-9 as digits. This block therefore guarantees `keycode` is stable across that edge.

## Interface
- `SCAN_DIV`, default 50000: clocks per column slot; range ≥ 4.
- `DEBOUNCE_CNT`, default 4: consecutive matching slot samples needed to accept a press or a release; range 1-15.

Ports:
- `clk`, input, 1: system clock, single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `row_in`, input, 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out`, output, 4: column drive, active-low, exactly one bit low at all times.
- `keycode`, output, 5: accepted key code; 5'h10 means no key.
- `key_ready`, output, 1: high while an accepted key is held.

## Operation
- **Input synchronisation:** `row_in` passes through a 2-flop synchroniser. All decisions use the synchronised value `rows_s`.
- **Slot timing:**
  - A slot counter counts 0 to `SCAN_DIV`-1.
  - `rows_s` is sampled only when the counter equals `SCAN_DIV`-1. This is the settle time after a column change.
- **Key map:** row r, column c maps as follows.
  - Row 0: 1, 2, 3, 10.
  - Row 1: 4, 5, 6, 11.
  - Row 2: 7, 8, 9, 12.
  - Row 3: 14, 0, 15, 13.
- **Valid sample:** exactly one `rows_s` bit is low.
- **Invalid sample:** zero or two or more bits low. Multi-key presses are ignored.
- **FSM states:**
  - SCAN: at slot end, a valid sample stores the row as the candidate, freezes `col_out`, and goes to DEB_P, with debounce count = 1. An invalid sample rotates `col_out` to the next column (3 wraps to 0).
  - DEB_P: at slot end, a sample equal to the candidate increments the count. When the count reaches `DEBOUNCE_CNT`, the FSM registers `keycode` and goes to HELD. Any other sample returns to SCAN and rotates the column.
  - HELD: `key_ready` is 1. At slot end, if `rows_s` = 4'hF, go to DEB_R with count = 1. Any other sample, including a second key, is ignored.
  - DEB_R: at slot end, `rows_s` = 4'hF increments the count. When the count reaches `DEBOUNCE_CNT`, go to DROP. Any other sample returns to HELD with the count cleared.
  - DROP: `key_ready` is 0 and `keycode` still holds its value. After exactly 2 clocks, `keycode` becomes 5'h10 and the FSM enters SCAN. The column rotates to the next one.
- **Column lock:** `col_out` never changes in DEB_P, HELD or DEB_R.
- **Debounce count:** the counter is 4 bits wide and saturates. It never wraps.

## Timing
- **Reset values:**
  - `col_out` = 4'b1110.
  - `keycode` = 5'h10.
  - `key_ready` = 0.
  - State = SCAN; slot and debounce counters = 0; synchroniser flops = 4'hF.
- **Press latency:** `keycode` updates on the clock edge where the final debounce sample is taken. `key_ready` rises on the next clock. `keycode` therefore leads `key_ready` by 1 cycle.
- **Release latency:** `key_ready` falls on the clock after the final release sample. `keycode` stays unchanged for 2 more clocks after the fall, then goes to 5'h10.
- **Minimum `key_ready` high time:** `DEBOUNCE_CNT`·`SCAN_DIV` clocks.
- **Nominal press detection:** (`DEBOUNCE_CNT`)·`SCAN_DIV` + 3 clocks after the key's column is driven with the key held. This includes 2 synchroniser cycles plus the register cycle.
- **Scan period:** 4·`SCAN_DIV` clocks in SCAN.
- **Reset mid-operation:** all outputs return to their reset values immediately, asynchronously. `key_ready` falling because of reset is allowed. Downstream may see a spurious edge, which is accepted.
- **Bounce longer than the debounce window:** each aborted DEB_P returns to SCAN. No `key_ready` pulse is produced.

## Test plan
Use `SCAN_DIV`=4 and `DEBOUNCE_CNT`=3 for all scenarios.
1. **Reset:** assert reset, release `rst_n`, `row_in`=4'hF. Required: `col_out` cycles 1110→1101→1011→0111→1110, one step every 4 clocks; `keycode`=5'h10; `key_ready`=0 throughout.
2. **Clean press of key "5":** pull `row_in[1]` low whenever `col_out[1]`=0, hold for 40 clocks, then release. Required: `keycode`=5; `key_ready` rises 1 clock after `keycode` and falls after 3 release samples; `keycode`=5 for 2 clocks after the fall, then 5'h10.
3. **Bounce:** key "#" (row 3, column 2) toggles every 5 clocks for 30 clocks, then is held stable. Required: no `key_ready` during the bounce; a single `key_ready` with `keycode`=15 after it settles.
4. **Two keys:** key "1" and key "4" (same column 0) pressed together. Required: never accepted. "1" accepted first, then "4" added while held. Required: `keycode` stays 1, and `key_ready` stays high until both keys are released.
5. **Release glitch:** during HELD on key "0", release for 1 sample, then press again. Required: the FSM returns to HELD, `key_ready` never drops, and `keycode` stays 0.
6. **Reset while held:** assert `rst_n` low while HELD on key "D". Required: `key_ready`=0 and `keycode`=5'h10 in the same cycle; after reset is released with the key still held, the key is reacquired with `keycode`=13.
